robo_ambiente: RTL
==================

# robo_ambiente

Synthesizable grid-world model that closes the loop around the wall-following robot controller: it consumes the robot's `avancar`/`girar` commands and produces the `head`/`left` wall-sensor inputs the controller reads. It holds robot position and heading on a parameterized obstacle map, detects collisions and goal arrival, and counts executed moves. It sits beside the controller in the top-level integration and simulation harness.

## Interface
- `LARGURA`, 4: grid width in cells (≥2)
- `ALTURA`, 4: grid height in cells (≥2)
- `MAPA`, 0: `LARGURA*ALTURA`-bit obstacle map; bit `y*LARGURA+x` = 1 means wall cell
- `X0`, `Y0`, 0, 0: start cell (must be free)
- `DIR0`, 0: start heading (0=N, 1=E, 2=S, 3=W)
- `GOAL_X`, `GOAL_Y`, 3, 3: goal cell
- `PASSOS_W`, 8: step counter width
- `MAX_PASSOS`, 200: timeout limit (used only with macro)
- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `avancar` in 1: move one cell forward this cycle
- `girar` in 1: rotate 90° clockwise this cycle
- `head` out 1: cell ahead is wall or outside grid
- `left` out 1: cell to the left (heading+3 mod 4) is wall or outside grid
- `pos_x` out `$clog2(LARGURA)`: current column
- `pos_y` out `$clog2(ALTURA)`: current row
- `dir` out 2: current heading
- `passos` out `PASSOS_W`: executed commands, saturating
- `colisao` out 1: one-cycle pulse, forward move blocked
- `chegou` out 1: robot at goal, sticky
- `esgotado` out 1: step limit reached, sticky (tied 0 without macro)

## Operation
- Coordinates: N = y+1, E = x+1, S = y−1, W = x−1; outside 0..LARGURA−1 / 0..ALTURA−1 counts as wall.
- `head`, `left` are combinational functions of registered `pos_x`, `pos_y`, `dir` only; never of `avancar`/`girar` → no combinational loop with the controller.
- Per rising edge, when not frozen:
  - `girar`=1: `dir` ← (`dir`+1) mod 4; `passos`+1. Takes priority; simultaneous `avancar` ignored.
  - else `avancar`=1, `head`=0: position ← cell ahead; `passos`+1.
  - else `avancar`=1, `head`=1: position unchanged; `colisao`=1 next cycle; `passos` unchanged.
  - neither: hold.
- `chegou` set at the edge where the new position equals goal; set at reset if start equals goal.
- Frozen when `chegou`=1 or `esgotado`=1: all commands ignored, `colisao` stays 0, state held until reset.
- `passos` saturates at 2^PASSOS_W−1.

## Timing
- Reset values: `pos_x`=X0, `pos_y`=Y0, `dir`=DIR0, `passos`=0, `colisao`=0, `esgotado`=0, `chegou`=(X0==GOAL_X && Y0==GOAL_Y); `head`/`left` reflect start pose in the same cycle.
- Command latency 1 cycle: pose/sensors update at the edge that samples the command.
- `colisao` high exactly the cycle after the blocked edge.
- Reset mid-operation overrides any command in the same cycle; no state survives.

## Configuration
- `ROBO_AMBIENTE_TIMEOUT_EN` defined: `esgotado` set at the edge where `passos` reaches `MAX_PASSOS` (the move itself executes); freezes the block.
- Undefined: no limit logic, `esgotado` constant 0, `MAX_PASSOS` unused.

## Structure
- Package `robo_pkg`: heading enum (`DIR_N`, `DIR_E`, `DIR_S`, `DIR_W`), rotate-clockwise and left-of functions, next-cell delta function.
- Sub-module `robo_sensor`: combinational lookup (pose, heading, `MAPA`) → wall flag; instantiated twice (ahead, left).

## Test plan
- Empty map, start (0,0) N: after reset `head`=0, `left`=1; 3× `avancar` → pos (0,3), `passos`=3, `head`=1.
- At (0,3) N, `avancar` → pos unchanged, `colisao` pulses 1 cycle, `passos` stays 3; then `girar` → `dir`=E, `head`=0, `left`=1.
- `MAPA` bit 1 set (wall at (1,0)), start (0,0) E: `head`=1; `avancar` and `girar` together → `dir`=S, no move, `colisao`=0, `passos`=1.
- Goal (2,0), start (0,0) E, empty map: 2× `avancar` → `chegou`=1; further `avancar` ignored, pos stays (2,0), `passos`=2.
- With macro, `MAX_PASSOS`=4: alternate `girar` in open space → `esgotado`=1 after 4th command, 5th ignored; assert `reset` during a command → reset values next cycle.

Source files
------------

// File: rtl/robo_pkg.sv
// robo_pkg: shared headings and pose arithmetic for the robo_ambiente grid world.
// Headings turn clockwise N -> E -> S -> W. North increases y and east increases x.
package robo_pkg;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    // Signed one-cell step taken when moving along a heading.
    typedef struct packed {
        int dx;
        int dy;
    } delta_t;

    // Heading after one 90-degree clockwise turn.
    function automatic dir_t rot_cw(dir_t d);
        logic [1:0] t;
        t = d + 2'd1;
        return dir_t'(t);
    endfunction

    // Heading pointing to the robot's left side (three clockwise turns).
    function automatic dir_t left_of(dir_t d);
        logic [1:0] t;
        t = d + 2'd3;
        return dir_t'(t);
    endfunction

    // Offset of the neighbouring cell in the given heading.
    function automatic delta_t delta(dir_t d);
        delta_t r;
        r.dx = 0;
        r.dy = 0;
        case (d)
            DIR_N:   r.dy = 1;
            DIR_E:   r.dx = 1;
            DIR_S:   r.dy = -1;
            default: r.dx = -1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/robo_ambiente_if.sv
// robo_ambiente_if: command and sensor bundle between the wall-following controller
// (master) and the grid-world environment (slave).
interface robo_ambiente_if #(
    parameter int LARGURA  = 4,
    parameter int ALTURA   = 4,
    parameter int PASSOS_W = 8
);
    import robo_pkg::*;

    localparam int XW = $clog2(LARGURA);
    localparam int YW = $clog2(ALTURA);

    logic                avancar;
    logic                girar;
    logic                head;
    logic                left;
    logic [XW-1:0]       pos_x;
    logic [YW-1:0]       pos_y;
    dir_t                dir;
    logic [PASSOS_W-1:0] passos;
    logic                colisao;
    logic                chegou;
    logic                esgotado;

    modport master (
        output avancar, girar,
        input  head, left, pos_x, pos_y, dir, passos, colisao, chegou, esgotado
    );

    modport slave (
        input  avancar, girar,
        output head, left, pos_x, pos_y, dir, passos, colisao, chegou, esgotado
    );

endinterface

// File: rtl/robo_sensor.sv
// robo_sensor: purely combinational wall lookup for the cell next to a pose in a given
// heading. Cells outside the grid are reported as walls.
module robo_sensor
    import robo_pkg::*;
#(
    parameter int                        LARGURA = 4,
    parameter int                        ALTURA  = 4,
    parameter logic [LARGURA*ALTURA-1:0] MAPA    = '0,
    localparam int                       XW      = $clog2(LARGURA),
    localparam int                       YW      = $clog2(ALTURA)
) (
    input  logic [XW-1:0] pos_x,
    input  logic [YW-1:0] pos_y,
    input  dir_t          heading,
    output logic          wall
);

    delta_t d;
    int     nx;
    int     ny;

    // Find the neighbouring cell, then report a wall if it is off-grid or set in the map.
    always_comb begin
        d    = delta(heading);
        nx   = int'(pos_x) + d.dx;
        ny   = int'(pos_y) + d.dy;
        wall = 1'b0;
        if (nx < 0 || nx >= LARGURA || ny < 0 || ny >= ALTURA) begin
            wall = 1'b1;
        end else begin
            for (int i = 0; i < LARGURA*ALTURA; i++) begin
                if (i == ny*LARGURA + nx) begin
                    wall = MAPA[i];
                end
            end
        end
    end

endmodule

// File: rtl/robo_ambiente.sv
// robo_ambiente: grid-world environment for the wall-following robot. It executes
// avancar/girar commands, keeps the pose, and feeds head/left wall sensors back.
// Optional macro ROBO_AMBIENTE_TIMEOUT_EN adds a step limit (esgotado) that freezes the block.
module robo_ambiente
    import robo_pkg::*;
#(
    parameter int                        LARGURA    = 4,
    parameter int                        ALTURA     = 4,
    parameter logic [LARGURA*ALTURA-1:0] MAPA       = '0,
    parameter int                        X0         = 0,
    parameter int                        Y0         = 0,
    parameter int                        DIR0       = 0,
    parameter int                        GOAL_X     = 3,
    parameter int                        GOAL_Y     = 3,
    parameter int                        PASSOS_W   = 8,
    parameter int                        MAX_PASSOS = 200
) (
    input logic            clock,
    input logic            reset,
    robo_ambiente_if.slave bus
);

    localparam int   XW      = $clog2(LARGURA);
    localparam int   YW      = $clog2(ALTURA);
    localparam logic CHEGOU0 = (X0 == GOAL_X) && (Y0 == GOAL_Y);

    logic [XW-1:0]       pos_x_q, pos_x_n;
    logic [YW-1:0]       pos_y_q, pos_y_n;
    dir_t                dir_q, dir_n;
    logic [PASSOS_W-1:0] passos_q, passos_n;
    logic                colisao_q, colisao_n;
    logic                chegou_q, chegou_n;
    logic                frozen;
    logic                head_w, left_w;
    delta_t              ahead;

`ifdef ROBO_AMBIENTE_TIMEOUT_EN
    logic esgotado_q, esgotado_n;
    assign frozen = chegou_q | esgotado_q;
`else
    assign frozen = chegou_q;
`endif

    robo_sensor #(.LARGURA(LARGURA), .ALTURA(ALTURA), .MAPA(MAPA)) u_sensor_head (
        .pos_x   (pos_x_q),
        .pos_y   (pos_y_q),
        .heading (dir_q),
        .wall    (head_w)
    );

    robo_sensor #(.LARGURA(LARGURA), .ALTURA(ALTURA), .MAPA(MAPA)) u_sensor_left (
        .pos_x   (pos_x_q),
        .pos_y   (pos_y_q),
        .heading (left_of(dir_q)),
        .wall    (left_w)
    );

    // Next pose and counters: turning wins over moving, a blocked move only raises colisao.
    always_comb begin
        pos_x_n   = pos_x_q;
        pos_y_n   = pos_y_q;
        dir_n     = dir_q;
        passos_n  = passos_q;
        colisao_n = 1'b0;
        chegou_n  = chegou_q;
        ahead     = delta(dir_q);
`ifdef ROBO_AMBIENTE_TIMEOUT_EN
        esgotado_n = esgotado_q;
`endif
        if (!frozen) begin
            if (bus.girar) begin
                dir_n    = rot_cw(dir_q);
                passos_n = (passos_q == '1) ? passos_q : passos_q + 1'b1;
            end else if (bus.avancar && !head_w) begin
                pos_x_n  = XW'(int'(pos_x_q) + ahead.dx);
                pos_y_n  = YW'(int'(pos_y_q) + ahead.dy);
                passos_n = (passos_q == '1) ? passos_q : passos_q + 1'b1;
                if (int'(pos_x_n) == GOAL_X && int'(pos_y_n) == GOAL_Y) begin
                    chegou_n = 1'b1;
                end
            end else if (bus.avancar) begin
                colisao_n = 1'b1;
            end
`ifdef ROBO_AMBIENTE_TIMEOUT_EN
            if (passos_n != passos_q && int'(passos_n) == MAX_PASSOS) begin
                esgotado_n = 1'b1;
            end
`endif
        end
    end

    // State register; reset restores the start pose and overrides any command.
    always_ff @(posedge clock) begin
        if (reset) begin
            pos_x_q   <= XW'(X0);
            pos_y_q   <= YW'(Y0);
            dir_q     <= dir_t'(DIR0[1:0]);
            passos_q  <= '0;
            colisao_q <= 1'b0;
            chegou_q  <= CHEGOU0;
`ifdef ROBO_AMBIENTE_TIMEOUT_EN
            esgotado_q <= 1'b0;
`endif
        end else begin
            pos_x_q   <= pos_x_n;
            pos_y_q   <= pos_y_n;
            dir_q     <= dir_n;
            passos_q  <= passos_n;
            colisao_q <= colisao_n;
            chegou_q  <= chegou_n;
`ifdef ROBO_AMBIENTE_TIMEOUT_EN
            esgotado_q <= esgotado_n;
`endif
        end
    end

    assign bus.head    = head_w;
    assign bus.left    = left_w;
    assign bus.pos_x   = pos_x_q;
    assign bus.pos_y   = pos_y_q;
    assign bus.dir     = dir_q;
    assign bus.passos  = passos_q;
    assign bus.colisao = colisao_q;
    assign bus.chegou  = chegou_q;
`ifdef ROBO_AMBIENTE_TIMEOUT_EN
    assign bus.esgotado = esgotado_q;
`else
    assign bus.esgotado = 1'b0;
`endif

endmodule
